// File: rtl/dffs_mp_init_pkg.sv
// dffs_mp_init shared package: state encoding, lane-width helper,
// and the packed-array access macros used across the register file.
`ifndef DFFS_MP_INIT_PKG_SV
`define DFFS_MP_INIT_PKG_SV

`define MIN(a, b) (((a) < (b)) ? (a) : (b))
`define PACK_ARRAY(W, i, v) v[(i)*(W) +: (W)]
`define UNPK_ARRAY(W, i, v) v[(i)*(W) +: (W)]

package dffs_mp_init_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  function automatic int lane_width(int wlen, int step);
    return `MIN(2 ** ($clog2(wlen) - step), wlen);
  endfunction

endpackage

`endif

// File: rtl/dffs_lane_merge.sv
// dffs_lane_merge: overlays NW lane-enabled words onto a base word.
// Lanes of higher-index ports override lower ones; disjoint lanes merge.
module dffs_lane_merge #(
  parameter int WLEN = 32,
  parameter int LW   = 8,
  parameter int NL   = 4,
  parameter int NW   = 2
) (
  input  logic [WLEN-1:0]    base,
  input  logic [NW*NL-1:0]   en,
  input  logic [NW*WLEN-1:0] data,
  output logic [WLEN-1:0]    word
);

  // later ports overwrite earlier ones, giving highest-index priority
  always_comb begin
    word = base;
    for (int k = 0; k < NW; k++) begin
      for (int b = 0; b < WLEN; b++) begin
        if (en[k*NL + b/LW]) word[b] = data[k*WLEN + b];
      end
    end
  end

endmodule

// File: rtl/dffs_mp_init.sv
// dffs_mp_init: multi-port flop register file with valid bits,
// self-init after reset and flash invalidate. Option: DFFS_BYPASS_EN.
module dffs_mp_init
  import dffs_mp_init_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int WLEN = 32,
  parameter int STEP = 2,
  parameter int NW   = 2,
  parameter int NR   = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    BUSY,
  input  logic                    FLUSH,
  input  logic [NW-1:0]           CENA,
  input  logic [NW*(2**STEP)-1:0] WENA,
  input  logic [NW*SIZE-1:0]      AA,
  input  logic [NW*WLEN-1:0]      DA,
  input  logic [NR-1:0]           CENB,
  input  logic [NR*SIZE-1:0]      AB,
  output logic [NR*WLEN-1:0]      QB,
  output logic [NR-1:0]           VB
);

  localparam int DEPTH = 2 ** SIZE;
  localparam int NL    = 2 ** STEP;
  localparam int LW    = lane_width(WLEN, STEP);

  if (LW * NL != WLEN) begin : g_lane_warn
    $warning("dffs_mp_init: lanes do not cover WLEN exactly");
  end

  state_t state;
  state_t state_nxt;
  logic [SIZE-1:0] cnt;
  logic idle;

  logic [NW*NL-1:0]            lane_en;
  logic [DEPTH-1:0][WLEN-1:0]  mem;
  logic [DEPTH-1:0][WLEN-1:0]  mem_nxt;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            valid_nxt;
  logic [DEPTH-1:0]            wr_hit;

  assign idle = (state == IDLE);

  // state register and init sweep counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  // leave INIT once the last entry has been cleared
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (&cnt) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // busy flag decoded from state
  always_comb BUSY = (state == INIT);

  // active-high lane enables, write ports muted during INIT
  always_comb begin
    for (int k = 0; k < NW; k++) begin
      for (int j = 0; j < NL; j++) begin
        lane_en[k*NL + j] = idle & ~CENA[k] & ~WENA[k*NL + j];
      end
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic [NW*NL-1:0] en_e;

    // keep only the lanes of ports addressing this entry
    always_comb begin
      for (int k = 0; k < NW; k++) begin
        if (`UNPK_ARRAY(SIZE, k, AA) == SIZE'(e))
          en_e[k*NL +: NL] = lane_en[k*NL +: NL];
        else
          en_e[k*NL +: NL] = '0;
      end
    end

    assign wr_hit[e] = |en_e;

    dffs_lane_merge #(
      .WLEN (WLEN),
      .LW   (LW),
      .NL   (NL),
      .NW   (NW)
    ) u_merge (
      .base (mem[e]),
      .en   (en_e),
      .data (DA),
      .word (mem_nxt[e])
    );
  end

  // a write to an entry beats a same-cycle flush
  always_comb valid_nxt = (FLUSH ? '0 : valid) | wr_hit;

  // data array: INIT clears one entry per cycle, IDLE commits writes
  always_ff @(posedge CLK) begin
    if (!idle) mem[cnt] <= '0;
    else       mem      <= mem_nxt;
  end

  // valid bits: cleared by reset and INIT, updated by writes/flush
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        valid      <= '0;
    else if (!idle) valid[cnt] <= 1'b0;
    else            valid      <= valid_nxt;
  end

  // registered read ports; hold when not enabled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      QB <= '0;
      VB <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (!CENB[r]) begin
          if (!idle) begin
            `PACK_ARRAY(WLEN, r, QB) <= '0;
            VB[r] <= 1'b0;
          end else begin
`ifdef DFFS_BYPASS_EN
            `PACK_ARRAY(WLEN, r, QB) <= mem_nxt[`UNPK_ARRAY(SIZE, r, AB)];
            VB[r] <= valid_nxt[`UNPK_ARRAY(SIZE, r, AB)];
`else
            `PACK_ARRAY(WLEN, r, QB) <= mem[`UNPK_ARRAY(SIZE, r, AB)];
            VB[r] <= valid[`UNPK_ARRAY(SIZE, r, AB)];
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dffs_mp_init.sv
// tb_dffs_mp_init: directed and random checks of dffs_mp_init
// against a lane-level behavioural model of the register file.
module tb_dffs_mp_init;

  localparam int SIZE  = 4;
  localparam int WLEN  = 32;
  localparam int STEP  = 2;
  localparam int NW    = 2;
  localparam int NR    = 2;
  localparam int NL    = 4;
  localparam int DEPTH = 16;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 BUSY;
  logic                 FLUSH = 1'b0;
  logic [NW-1:0]        CENA = '1;
  logic [NW*NL-1:0]     WENA = '1;
  logic [NW*SIZE-1:0]   AA = '0;
  logic [NW*WLEN-1:0]   DA = '0;
  logic [NR-1:0]        CENB = '1;
  logic [NR*SIZE-1:0]   AB = '0;
  logic [NR*WLEN-1:0]   QB;
  logic [NR-1:0]        VB;

  dffs_mp_init #(
    .SIZE (SIZE),
    .WLEN (WLEN),
    .STEP (STEP),
    .NW   (NW),
    .NR   (NR)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .BUSY  (BUSY),
    .FLUSH (FLUSH),
    .CENA  (CENA),
    .WENA  (WENA),
    .AA    (AA),
    .DA    (DA),
    .CENB  (CENB),
    .AB    (AB),
    .QB    (QB),
    .VB    (VB)
  );

  always #5 CLK = ~CLK;

`ifdef DFFS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [31:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  int          m_cnt;
  bit          m_init;
  logic [31:0] m_qb [NR];
  bit          m_vb [NR];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1;
    m_cnt  = 0;
    for (int e = 0; e < DEPTH; e++) m_val[e] = 1'b0;
    for (int r = 0; r < NR; r++) begin
      m_qb[r] = '0;
      m_vb[r] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] nm [DEPTH];
    bit          nv [DEPTH];
    bit          wr [DEPTH];
    int          a;
    if (m_init) begin
      for (int r = 0; r < NR; r++) begin
        if (!CENB[r]) begin
          m_qb[r] = '0;
          m_vb[r] = 1'b0;
        end
      end
      m_mem[m_cnt] = '0;
      m_val[m_cnt] = 1'b0;
      m_cnt++;
      if (m_cnt == DEPTH) m_init = 1'b0;
      return;
    end
    for (int e = 0; e < DEPTH; e++) begin
      nm[e] = m_mem[e];
      wr[e] = 1'b0;
    end
    for (int k = 0; k < NW; k++) begin
      if (!CENA[k]) begin
        a = int'(AA[k*SIZE +: SIZE]);
        for (int j = 0; j < NL; j++) begin
          if (!WENA[k*NL + j]) begin
            nm[a][j*8 +: 8] = DA[k*WLEN + j*8 +: 8];
            wr[a] = 1'b1;
          end
        end
      end
    end
    for (int e = 0; e < DEPTH; e++) nv[e] = (FLUSH ? 1'b0 : m_val[e]) | wr[e];
    for (int r = 0; r < NR; r++) begin
      if (!CENB[r]) begin
        a = int'(AB[r*SIZE +: SIZE]);
        m_qb[r] = BYP ? nm[a] : m_mem[a];
        m_vb[r] = BYP ? nv[a] : m_val[a];
      end
    end
    for (int e = 0; e < DEPTH; e++) begin
      m_mem[e] = nm[e];
      m_val[e] = nv[e];
    end
  endtask

  task automatic chk_all();
    chk("busy", 32'(BUSY), 32'(m_init));
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("qb%0d", r), QB[r*WLEN +: WLEN], m_qb[r]);
      chk($sformatf("vb%0d", r), 32'(VB[r]), 32'(m_vb[r]));
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk_all();
  endtask

  task automatic idle_in();
    CENA  = '1;
    WENA  = '1;
    CENB  = '1;
    FLUSH = 1'b0;
  endtask

  task automatic wr(int p, int addr, logic [31:0] d, logic [3:0] we);
    CENA[p] = 1'b0;
    AA[p*SIZE +: SIZE] = SIZE'(addr);
    DA[p*WLEN +: WLEN] = d;
    WENA[p*NL +: NL] = we;
  endtask

  task automatic rd(int p, int addr);
    CENB[p] = 1'b0;
    AB[p*SIZE +: SIZE] = SIZE'(addr);
  endtask

  task automatic async_reset();
    RST = 1'b1;
    model_reset();
    #1;
    chk("rst_busy", 32'(BUSY), 32'd1);
    chk("rst_vb", 32'(VB), 32'd0);
    for (int r = 0; r < NR; r++) chk("rst_qb", QB[r*WLEN +: WLEN], 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic count_init(string tag, bit poke);
    int n = 0;
    while (BUSY && n < 40) begin
      idle_in();
      if (poke && n == 4) wr(0, 6, 32'hCAFEF00D, 4'b0000);
      if (poke && n == 5) FLUSH = 1'b1;
      step();
      n++;
    end
    idle_in();
    chk(tag, 32'(n), 32'd16);
  endtask

  initial begin
    logic [31:0] exp4;
    #2;
    async_reset();
    count_init("init_len", 1'b1);

    for (int a = 0; a < DEPTH; a++) begin
      idle_in();
      rd(a % 2, a);
      step();
      chk("post_init_qb", QB[(a%2)*WLEN +: WLEN], 32'd0);
      chk("post_init_vb", 32'(VB[a%2]), 32'd0);
    end

    idle_in(); wr(0, 3, 32'hDEADBEEF, 4'b0000); step();
    idle_in(); rd(1, 3); step();
    chk("rd_deadbeef", QB[WLEN +: WLEN], 32'hDEADBEEF);
    chk("rd_deadbeef_v", 32'(VB[1]), 32'd1);

    idle_in();
    wr(0, 5, 32'h11111111, 4'b0000);
    wr(1, 5, 32'h22222222, 4'b1100);
    step();
    idle_in(); rd(0, 5); step();
    chk("lane_merge", QB[0 +: WLEN], 32'h11112222);

    idle_in(); wr(0, 7, 32'h77, 4'b0000); step();
    idle_in(); FLUSH = 1'b1; wr(1, 2, 32'hA5, 4'b0000); step();
    idle_in(); rd(0, 7); rd(1, 2); step();
    chk("flush_v7", 32'(VB[0]), 32'd0);
    chk("flush_v2", 32'(VB[1]), 32'd1);
    chk("flush_d7", QB[0 +: WLEN], 32'h77);
    chk("flush_d2", QB[WLEN +: WLEN], 32'hA5);

    exp4 = BYP ? 32'h55 : 32'h0;
    idle_in(); rd(0, 4); wr(1, 4, 32'h55, 4'b0000); step();
    chk("rw_same_q", QB[0 +: WLEN], exp4);
    chk("rw_same_v", 32'(VB[0]), 32'(BYP));

    for (int i = 0; i < 400; i++) begin
      CENA  = NW'($urandom);
      WENA  = (NW*NL)'($urandom);
      AA    = (NW*SIZE)'($urandom) & {NW{4'h7}};
      DA    = {$urandom, $urandom};
      CENB  = NR'($urandom);
      AB    = (NR*SIZE)'($urandom) & {NR{4'h7}};
      FLUSH = ($urandom_range(0, 15) == 0);
      step();
    end

    for (int a = 0; a < DEPTH; a++) begin
      idle_in();
      rd(0, a);
      rd(1, DEPTH - 1 - a);
      step();
    end

    idle_in(); wr(0, 9, 32'h12345678, 4'b0000); step();
    idle_in(); rd(0, 9); step();
    chk("pre_rst_q", QB[0 +: WLEN], 32'h12345678);
    idle_in();
    #2;
    async_reset();
    for (int i = 0; i < 9; i++) begin
      idle_in();
      step();
    end
    #2;
    async_reset();
    count_init("restart_len", 1'b0);

    idle_in(); rd(0, 9); rd(1, 3); step();
    chk("after_rst_q9", QB[0 +: WLEN], 32'd0);
    chk("after_rst_v3", 32'(VB[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dffs_mp_init.md
Name: dffs_mp_init

Overview:
- Flop-based register file with NR synchronous read ports and NW write ports; each write port has per-lane write enables.
- Each entry carries a valid bit. The array self-initialises after reset and supports a flash invalidate.
- Generalised successor of the single- and dual-port flop arrays in core-sodium. Sits behind scoreboards, tag arrays and small register files that need a known-clean state.

Parameters:
- SIZE, 4, log2 of entry count (DEPTH = 2**SIZE)
- WLEN, 32, bits per entry
- STEP, 2, log2 of lane count; lane width LW = MIN(2**(clog2(WLEN)-STEP), WLEN)
- NW, 2, number of write ports
- NR, 2, number of read ports

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- BUSY  out  1  high while the init sequence runs
- FLUSH  in  1  active-high; clears all valid bits
- CENA  in  NW  per-write-port chip enable, active-low
- WENA  in  NW*2**STEP  per-port lane write enables, active-low; port k occupies bits [k*2**STEP +: 2**STEP]
- AA  in  NW*SIZE  write addresses, packed per port
- DA  in  NW*WLEN  write data, packed per port
- CENB  in  NR  per-read-port chip enable, active-low
- AB  in  NR*SIZE  read addresses, packed per port
- QB  out  NR*WLEN  read data, packed per port, registered
- VB  out  NR  valid bit of the read entry, registered

Behaviour:
- Reset (RST=1, asynchronous):
  - FSM goes to INIT, init counter = 0, BUSY=1.
  - All QB=0, all VB=0, all valid bits=0.
  - Data array is not reset by RST; the INIT sequence clears it.
- FSM states:
  - INIT: each cycle writes 0 to entry[cnt] and clears valid[cnt], then cnt++. When cnt==DEPTH-1 the FSM moves to IDLE on the next edge. INIT lasts exactly DEPTH cycles after RST falls.
  - IDLE: BUSY=0.
  - RST asserted mid-INIT restarts the sequence at cnt=0.
- During INIT:
  - All write ports are ignored.
  - Read ports with CENB low update QB=0 and VB=0.
- Write, in IDLE:
  - Port k writes when CENA[k]=0. Lane j of entry AA[k] takes DA[k] lane j where WENA[k][j]=0.
  - valid[AA[k]] is set if any lane of port k is written.
  - Same entry and same lane on several ports: the highest port index wins. Disjoint lanes merge.
- Read, in IDLE: 1-cycle latency.
  - CENB[r]=0 at edge t: at t+1, QB[r]=entry[AB[r]] and VB[r]=valid[AB[r]], both sampled before the edge-t writes (read-first).
  - CENB[r]=1: QB[r] and VB[r] hold their value.
- FLUSH (IDLE only):
  - All valid bits are 0 after the edge.
  - A write in the same cycle to entry e still sets valid[e]; the write beats FLUSH.
  - A read in the same cycle returns pre-flush valid.
  - Data is untouched.
  - FLUSH is ignored during INIT.
- Widths:
  - Addresses are all in range because DEPTH = 2**SIZE, so no wrap logic is needed.
  - Lanes cover WLEN exactly when LW*2**STEP==WLEN. Otherwise excess lanes are unused and the tool must warn.

Optional Feature:
- Macro: DFFS_BYPASS_EN.
- Defined: each read port forwards same-cycle writes to its address, lane-merged with the same port priority as the array. QB reflects post-write data and VB=1 if any lane was written (write-first). A same-cycle FLUSH without a write to that address forces VB=0.
- Undefined: pure read-first as described above; no forwarding mux.

Decomposition:
- Shared package/defines: the MIN macro, the PACK_ARRAY/UNPK_ARRAY macros, lane-width computation, and FSM state encodings (INIT=1'b0, IDLE=1'b1).
- One sub-module, dffs_lane_merge: takes a base word plus NW (lane-enable, data) pairs and returns the priority-merged word. It is used by the array write path and by the bypass path.

Test Plan:
- Release RST, DEPTH=16 → BUSY=1 for exactly 16 cycles. Then reads of all addresses give QB=0, VB=0. A write attempted during INIT is not visible afterwards.
- Port0 writes 0xDEADBEEF to addr 3, all lanes; next cycle port1 reads addr 3 → QB=0xDEADBEEF, VB=1 one cycle later.
- Same cycle: port0 writes 0x11111111 and port1 writes 0x22222222 to addr 5 with WENA1=4'b1100 → addr 5 = 0x11112222.
- Addr 7 valid; assert FLUSH with a same-cycle write of 0xA5 to addr 2 → afterwards VB(7)=0, VB(2)=1, data at 7 is unchanged.
- Read addr 4 (old 0x0) while writing 0x55 to addr 4 → without DFFS_BYPASS_EN QB=0x0; with it QB=0x55.
- Assert RST at INIT cnt=9 → BUSY stays high and the count restarts. QB/VB go to 0 immediately, asynchronously.
